// File: rtl/ksa_swap_loop_if.sv
// ksa_swap_loop_if: start/key request plus s-memory port of the RC4 key-schedule swap loop
interface ksa_swap_loop_if #(
  parameter int KEY_LEN = 3
);
  logic                   start;
  logic [8*KEY_LEN-1:0]   secret_key;
  logic [7:0]             q;
  logic [7:0]             address;
  logic [7:0]             data;
  logic                   wren;
  logic                   done;
  modport master (output start, secret_key, q, input address, data, wren, done);
  modport slave  (input start, secret_key, q, output address, data, wren, done);
endinterface

// File: rtl/ksa_swap_loop.sv
// ksa_swap_loop: RC4 key-scheduling swap loop over a 256-byte s-memory (clk, reset, bus: start/secret_key/q in, address/data/wren/done out; optional KSA_SELF_SWAP_SKIP_EN skips self-swaps)
module ksa_swap_loop #(
  parameter int KEY_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  ksa_swap_loop_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [4:0] k_q, k_d, k_nxt;
  logic [8*KEY_LEN-1:0] key_sh;
  logic [7:0] key_byte, j_upd;
  logic last;
`ifdef KSA_SELF_SWAP_SKIP_EN
  logic skip_q, skip_d;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
`ifdef KSA_SELF_SWAP_SKIP_EN
      skip_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
`ifdef KSA_SELF_SWAP_SKIP_EN
      skip_q  <= skip_d;
`endif
    end
  end
  // Byte k sits k bytes below the MSB; shifting it to the top avoids a variable part-select.
  always_comb begin
    key_sh   = bus.secret_key << {k_q, 3'b000};
    key_byte = key_sh[8*KEY_LEN-1 -: 8];
    j_upd    = j_q + bus.q + key_byte;
    k_nxt    = (k_q == 5'(KEY_LEN - 1)) ? 5'd0 : k_q + 5'd1;
    last     = (i_q == 8'hff);
  end
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    si_d        = si_q;
    sj_d        = sj_q;
`ifdef KSA_SELF_SWAP_SKIP_EN
    skip_d      = skip_q;
`endif
    bus.address = '0;
    bus.data    = '0;
    bus.wren    = 1'b0;
    bus.done    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        bus.done = (state_q == DONE);
        if (bus.start) begin
          state_d = RD_I;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      RD_I: begin
        bus.address = i_q;
        state_d     = WAIT_I;
      end
      WAIT_I: begin
        si_d    = bus.q;
        j_d     = j_upd;
`ifdef KSA_SELF_SWAP_SKIP_EN
        skip_d  = (j_upd == i_q);
`endif
        state_d = RD_J;
      end
      RD_J: begin
        bus.address = j_q;
        state_d     = WAIT_J;
`ifdef KSA_SELF_SWAP_SKIP_EN
        // s[i] == s[j] when j == i, so the two writes would change nothing.
        if (skip_q) begin
          state_d = last ? DONE : RD_I;
          i_d     = i_q + 8'd1;
          k_d     = k_nxt;
        end
`endif
      end
      WAIT_J: begin
        sj_d    = bus.q;
        state_d = WR_I;
      end
      WR_I: begin
        bus.address = i_q;
        bus.data    = sj_q;
        bus.wren    = 1'b1;
        state_d     = WR_J;
      end
      WR_J: begin
        bus.address = j_q;
        bus.data    = si_q;
        bus.wren    = 1'b1;
        state_d     = last ? DONE : RD_I;
        i_d         = i_q + 8'd1;
        k_d         = k_nxt;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/ksa_swap_loop.md
KSA_SWAP_LOOP -- requirements
Module: ksa_swap_loop

Interface
REQ-001 Parameter: KEY_LEN, 3, secret-key length in bytes (legal range 1..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to run the swap loop; sampled only in IDLE or DONE.
REQ-005 secret_key  input  8*KEY_LEN  key bytes; byte 0 = most-significant byte.
REQ-006 q  input  8  s-memory read data; valid the cycle after the read address is presented.
REQ-007 address  output  8  s-memory address.
REQ-008 data  output  8  s-memory write data.
REQ-009 wren  output  1  s-memory write enable.
REQ-010 done  output  1  level; high while loop is complete; drives the downstream memory-port select.

Function
REQ-011 The block SHALL perform the RC4 key-scheduling swap loop: for i = 0..255: j = (j + s[i] + key[i mod KEY_LEN]) mod 256, then swap s[i] and s[j].
REQ-012 All j arithmetic SHALL be 8-bit, wrapping modulo 256.
REQ-013 key[i mod KEY_LEN] SHALL come from a key-index counter k, cleared with i and wrapping from KEY_LEN-1 to 0; no divider.
REQ-014 States: IDLE, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, DONE.
REQ-015 IDLE: start=1 -> RD_I with i=j=k=0; start=0 -> stay.
REQ-016 RD_I: address=i, wren=0 -> WAIT_I.
REQ-017 WAIT_I: capture si=q; update j from si, the current j, and key byte k; -> RD_J.
REQ-018 RD_J: address=j (updated value), wren=0 -> WAIT_J.
REQ-019 WAIT_J: capture sj=q -> WR_I.
REQ-020 WR_I: address=i, data=sj, wren=1 -> WR_J.
REQ-021 WR_J: address=j, data=si, wren=1; if i=255 -> DONE, else i++, k advance -> RD_I.
REQ-022 address, data, and wren SHALL be functions of the state and internal registers only; no combinational path from q.
REQ-023 wren SHALL be 0 in every state other than WR_I and WR_J.
REQ-024 A normal iteration SHALL take 6 cycles; 256 iterations SHALL take 1536 cycles.
REQ-025 done SHALL be 1 only in DONE; DONE holds while start=0.
REQ-026 DONE with start=1 SHALL restart: done falls on the next edge, i=j=k=0, -> RD_I.
REQ-027 start SHALL be ignored in RD_I through WR_J.
REQ-028 secret_key SHALL be held stable by the source while busy; the block does not register it.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE with i=j=k=0, si=sj=0, address=0, data=0, wren=0, done=0, regardless of state.
REQ-030 reset SHALL take priority over start.
REQ-031 Reset during WR_I or WR_J SHALL deassert wren from the next cycle; a partially swapped memory is accepted.

Configuration
REQ-032 Macro KSA_SELF_SWAP_SKIP_EN: when defined, WAIT_I SHALL compare the updated j with i.
REQ-033 On equality with the macro defined, WAIT_J, WR_I, and WR_J SHALL be skipped: RD_J -> i++ -> RD_I, or RD_J -> DONE if i=255; no writes occur and the iteration takes 3 cycles.
REQ-034 Without the macro, self-swaps SHALL execute normally with two writes of the same value; cycle count is fixed at 1536.
REQ-035 The final memory contents SHALL be identical with and without the macro.

Verification
REQ-036 Identity s[n]=n, KEY_LEN=3, key 24'h000000, no macro -> first writes differing from read are addr 2 data 3, then addr 3 data 2 (j sequence 0,1,3).
REQ-037 Same stimulus, no macro -> done rises in cycle 1537 after the edge sampling start; exactly 512 wren cycles.
REQ-038 Same stimulus, KSA_SELF_SWAP_SKIP_EN defined -> no wren during i=0 and i=1; final memory bit-identical to REQ-037 run.
REQ-039 Key 24'h01_02_03, identity s -> final s matches a software RC4 KSA model for all 256 entries; k sequence 0,1,2,0...
REQ-040 reset asserted in WR_I of iteration 100 -> next cycle state IDLE, wren=0, done=0; a later start runs a full 1536-cycle loop.
REQ-041 start held high through DONE -> done high for one cycle, then the loop restarts with i=j=0; start pulses mid-loop have no effect.
